// File: rtl/rom_loader_if.sv
// Memory-side bus between the loader and the rom/ram instances.
// The master side is the loader: it drives addresses and write data,
// and it receives read data from a synchronous ROM and a synchronous RAM.
interface rom_loader_if;
   logic [15:0] rom_addr;
   logic [7:0]  rom_dout;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;

   modport master (
      output rom_addr,
      input  rom_dout,
      output ram_addr,
      output ram_din,
      output ram_we,
      input  ram_dout
   );

   modport slave (
      input  rom_addr,
      output rom_dout,
      input  ram_addr,
      input  ram_din,
      input  ram_we,
      output ram_dout
   );
endinterface

// File: rtl/rom_loader.sv
// Boot/program sequencer and owner of the ROM and RAM ports.
// Sequence: clear RAM, copy the font, read the slot directory entry,
// copy the selected program to PROG_DEST, then hand both memories to the cpu.
module rom_loader #(
   parameter int unsigned CLEAR_LEN = 4096,
   parameter logic [15:0] FONT_BASE = 16'h0000,
   parameter int unsigned FONT_LEN  = 80,
   parameter logic [15:0] FONT_DEST = 16'h0050,
   parameter logic [15:0] DIR_BASE  = 16'h0050,
   parameter logic [15:0] PROG_DEST = 16'h0200,
   parameter logic [15:0] PROG_MAX  = 16'h0E00,
   parameter bit          AUTOSTART = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  slot,
   output logic        busy,
   output logic        cpu_run,
   output logic        load_err,
   output logic        trunc,
   input  logic [15:0] cpu_rom_addr,
   output logic [7:0]  cpu_rom_dout,
   input  logic [15:0] cpu_ram_addr,
   input  logic [7:0]  cpu_ram_din,
   input  logic        cpu_ram_we,
   output logic [7:0]  cpu_ram_dout,
   rom_loader_if.master mem
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FONT,
      S_DIR,
      S_PROG,
      S_RUN,
      S_ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        go;
   logic [15:0] cnt;
   logic [3:0]  slot_q;
   logic [7:0]  start_hi;
   logic [7:0]  len_hi;
   logic [15:0] prog_start;
   logic [15:0] prog_len;
   logic        trunc_q;
   logic        auto_pend;
   logic [15:0] dir_addr;
   logic [15:0] dir_len;

   assign dir_addr = DIR_BASE + {10'd0, slot_q, 2'b00};
   assign dir_len  = {len_hi, mem.rom_dout};

   // Status decode straight from the state so reset clears it asynchronously.
   always_comb begin
      busy     = (state == S_CLEAR) || (state == S_FONT) ||
                 (state == S_DIR)   || (state == S_PROG);
      cpu_run  = (state == S_RUN);
      load_err = (state == S_ERR);
      trunc    = trunc_q;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a start request is only honoured when not loading.
   always_comb begin
      go        = 1'b0;
      state_nxt = state;
      case (state)
         S_IDLE: begin
            go = start | auto_pend;
            if (go) state_nxt = S_CLEAR;
         end
         S_RUN, S_ERR: begin
            go = start;
            if (go) state_nxt = S_CLEAR;
         end
         S_CLEAR: if (cnt == 16'(CLEAR_LEN - 1)) state_nxt = S_FONT;
         S_FONT:  if (cnt == 16'(FONT_LEN))      state_nxt = S_DIR;
         S_DIR: begin
            if (cnt == 16'd4) state_nxt = (dir_len == '0) ? S_ERR : S_PROG;
         end
         S_PROG:  if (cnt == prog_len)           state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory port mux: loader address generation while loading, cpu pass-through in RUN.
   always_comb begin
      mem.rom_addr = '0;
      mem.ram_addr = '0;
      mem.ram_din  = '0;
      mem.ram_we   = 1'b0;
      cpu_rom_dout = '0;
      cpu_ram_dout = '0;
      case (state)
         S_CLEAR: begin
            mem.ram_addr = cnt;
            mem.ram_we   = 1'b1;
         end
         S_FONT: begin
            // Read issued at step k lands one clock later, written as byte k-1.
            mem.rom_addr = FONT_BASE + cnt;
            if (cnt != '0) begin
               mem.ram_addr = FONT_DEST + cnt - 16'd1;
               mem.ram_din  = mem.rom_dout;
               mem.ram_we   = 1'b1;
            end
         end
         S_DIR: begin
            mem.rom_addr = dir_addr + cnt;
         end
         S_PROG: begin
            mem.rom_addr = prog_start + cnt;
            if (cnt != '0) begin
               mem.ram_addr = PROG_DEST + cnt - 16'd1;
               mem.ram_din  = mem.rom_dout;
               mem.ram_we   = 1'b1;
            end
         end
         S_RUN: begin
            mem.rom_addr = cpu_rom_addr;
            cpu_rom_dout = mem.rom_dout;
            mem.ram_addr = cpu_ram_addr;
            mem.ram_din  = cpu_ram_din;
            mem.ram_we   = cpu_ram_we;
            cpu_ram_dout = mem.ram_dout;
         end
         default: ;
      endcase
   end

   // Step counter, slot latch and directory capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         slot_q     <= '0;
         start_hi   <= '0;
         len_hi     <= '0;
         prog_start <= '0;
         prog_len   <= '0;
         trunc_q    <= 1'b0;
         auto_pend  <= AUTOSTART;
      end else begin
         if (state_nxt != state) cnt <= '0;
         else if (busy)          cnt <= cnt + 16'd1;

         if (go) begin
            slot_q    <= slot;
            trunc_q   <= 1'b0;
            auto_pend <= 1'b0;
         end

         // Directory bytes arrive one clock after their address: start hi/lo, len hi/lo.
         if (state == S_DIR) begin
            case (cnt)
               16'd1: start_hi   <= mem.rom_dout;
               16'd2: prog_start <= {start_hi, mem.rom_dout};
               16'd3: len_hi     <= mem.rom_dout;
               16'd4: begin
                  if (dir_len > PROG_MAX) begin
                     prog_len <= PROG_MAX;
                     trunc_q  <= 1'b1;
                  end else begin
                     prog_len <= dir_len;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader with behavioural ROM/RAM and a
// spec-level model of the RAM image, load time and status flags.
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  slot;
   logic        busy, cpu_run, load_err, trunc;
   logic [15:0] cpu_rom_addr;
   logic [7:0]  cpu_rom_dout;
   logic [15:0] cpu_ram_addr;
   logic [7:0]  cpu_ram_din;
   logic        cpu_ram_we;
   logic [7:0]  cpu_ram_dout;

   rom_loader_if bus();

   rom_loader #(
      .CLEAR_LEN(4096),
      .FONT_LEN(80),
      .PROG_MAX(16'h0E00),
      .AUTOSTART(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .slot(slot),
      .busy(busy),
      .cpu_run(cpu_run),
      .load_err(load_err),
      .trunc(trunc),
      .cpu_rom_addr(cpu_rom_addr),
      .cpu_rom_dout(cpu_rom_dout),
      .cpu_ram_addr(cpu_ram_addr),
      .cpu_ram_din(cpu_ram_din),
      .cpu_ram_we(cpu_ram_we),
      .cpu_ram_dout(cpu_ram_dout),
      .mem(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [0:65535];
   logic [7:0] ram [0:65535];
   logic       ram_fill;
   int         wr_total = 0;
   int         stray = 0;
   logic [15:0] last_wr = '0;

   int checks = 0;
   int errors = 0;

   // Synchronous ROM and RAM models plus write monitors.
   always @(posedge clk) begin
      bus.rom_dout <= rom[bus.rom_addr];
      bus.ram_dout <= ram[bus.ram_addr];
      if (ram_fill) begin
         for (int i = 0; i < 65536; i++) ram[i] <= 8'hFF;
      end else if (bus.ram_we) begin
         ram[bus.ram_addr] <= bus.ram_din;
      end
      if (bus.ram_we && busy) begin
         wr_total <= wr_total + 1;
         last_wr  <= bus.ram_addr;
      end
      if (bus.ram_we && !busy && !cpu_run) stray <= stray + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_dir(input logic [3:0] s, input logic [15:0] st, input logic [15:0] ln);
      int b;
      b = 16'h0050 + 4 * int'(s);
      rom[b]     = st[15:8];
      rom[b + 1] = st[7:0];
      rom[b + 2] = ln[15:8];
      rom[b + 3] = ln[7:0];
   endtask

   task automatic issue_start(input logic [3:0] s);
      @(negedge clk);
      slot  = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts clocks from the edge that accepted the request (that edge is 1).
   task automatic wait_done(output int n);
      n = 1;
      forever begin
         @(negedge clk);
         if (n == 1)
            chk("early_status", {busy, cpu_run, cpu_rom_dout, cpu_ram_dout}, {1'b1, 1'b0, 16'h0000});
         if (cpu_run || load_err || n >= 20000) break;
         @(posedge clk);
         n++;
      end
   endtask

   // Spec-level expectation for a load of slot s that finished after n clocks.
   task automatic verify(input string tag, input logic [3:0] s, input int n, input int wr_base,
                         output bit m_err, output bit m_tr);
      int          b, exp_n, bad;
      logic [15:0] st, ln, plen, ra;
      logic [7:0]  e;
      b  = 16'h0050 + 4 * int'(s);
      st = {rom[b], rom[b + 1]};
      ln = {rom[b + 2], rom[b + 3]};
      m_err = (ln == 16'h0000);
      m_tr  = (ln > 16'h0E00);
      plen  = m_tr ? 16'h0E00 : ln;
      exp_n = m_err ? (4096 + 81 + 5 + 1) : (4096 + 81 + 5 + int'(plen) + 1 + 1);
      chk({tag, ".cycles"}, n, exp_n);
      chk({tag, ".run"}, cpu_run, !m_err);
      chk({tag, ".err"}, load_err, m_err);
      chk({tag, ".trunc"}, trunc, m_tr);
      chk({tag, ".busy"}, busy, 0);
      bad = 0;
      for (int a = 0; a < 65536; a++) begin
         e = (a < 4096) ? 8'h00 : 8'hFF;
         if (a >= 16'h0050 && a < 16'h00A0) e = rom[a - 16'h0050];
         if (!m_err && a >= 16'h0200 && a < 16'h0200 + int'(plen)) begin
            ra = st + 16'(a - 16'h0200);
            e  = rom[ra];
         end
         if (ram[a] !== e) bad++;
      end
      chk({tag, ".image"}, bad, 0);
      chk({tag, ".writes"}, wr_total - wr_base, 4096 + 80 + (m_err ? 0 : int'(plen)));
      if (!m_err) chk({tag, ".last_wr"}, last_wr, 16'h0200 + plen - 16'd1);
   endtask

   typedef struct {
      logic [3:0]  slot;
      logic [15:0] pstart;
      logic [15:0] plen;
      bit          err;
      bit          tr;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int n, wb;
      bit me, mt;
      logic [3:0] rs;

      vecs[0] = '{4'd3,  16'h2000, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{4'd0,  16'h1000, 16'h0004, 1'b0, 1'b0};
      vecs[2] = '{4'd5,  16'h3000, 16'h1000, 1'b0, 1'b1};
      vecs[3] = '{4'd15, 16'hFFFE, 16'h0006, 1'b0, 1'b0};
      vecs[4] = '{4'd7,  16'h4000, 16'h0E00, 1'b0, 1'b0};
      vecs[5] = '{4'd8,  16'h8000, 16'h0001, 1'b0, 1'b0};

      reset = 1'b0; start = 1'b0; slot = 4'd0; ram_fill = 1'b1;
      cpu_rom_addr = '0; cpu_ram_addr = '0; cpu_ram_din = '0; cpu_ram_we = 1'b0;
      for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
      for (int s = 0; s < 16; s++) set_dir(4'(s), 16'($urandom), 16'($urandom_range(1, 16)));
      set_dir(4'd0, 16'h1000, 16'h0004);
      rom[16'h1000] = 8'hA1; rom[16'h1001] = 8'hB2; rom[16'h1002] = 8'hC3; rom[16'h1003] = 8'hD4;

      @(posedge clk); #1 ram_fill = 1'b0;
      @(negedge clk);
      chk("reset_status", {busy, cpu_run, load_err, trunc, bus.ram_we}, 5'b0);
      chk("reset_addr", {bus.rom_addr, bus.ram_addr}, 32'h0);

      // Autostart of slot 0 on reset release.
      slot = 4'd0;
      reset = 1'b1;
      @(posedge clk); #1 wb = wr_total;
      wait_done(n);
      verify("auto0", 4'd0, n, wb, me, mt);
      chk("prog_bytes", {ram[16'h200], ram[16'h201], ram[16'h202], ram[16'h203]}, 32'hA1B2C3D4);
      chk("prog_tail", ram[16'h204], 8'h00);

      // cpu access through the transparent muxes.
      cpu_ram_addr = 16'h0300; cpu_ram_din = 8'h5A; cpu_ram_we = 1'b1;
      @(negedge clk); cpu_ram_we = 1'b0;
      @(negedge clk);
      chk("cpu_ram_rd", cpu_ram_dout, 8'h5A);
      cpu_rom_addr = 16'h1001;
      @(negedge clk);
      chk("cpu_rom_rd", cpu_rom_dout, 8'hB2);

      // Directory table: error, recovery, truncation, address wrap, exact max, len 1.
      for (int i = 0; i < 6; i++) begin
         set_dir(vecs[i].slot, vecs[i].pstart, vecs[i].plen);
         issue_start(vecs[i].slot);
         wb = wr_total;
         wait_done(n);
         verify($sformatf("vec%0d", i), vecs[i].slot, n, wb, me, mt);
         chk($sformatf("vec%0d.tbl_err", i), load_err, vecs[i].err);
         chk($sformatf("vec%0d.tbl_trunc", i), trunc, vecs[i].tr);
      end

      // A start during FONT must neither change the slot nor the timing.
      set_dir(4'd1, 16'h7000, 16'h0003);
      set_dir(4'd2, 16'h7100, 16'h0020);
      issue_start(4'd1);
      wb = wr_total;
      fork
         wait_done(n);
         begin
            repeat (4100) @(posedge clk);
            @(negedge clk); slot = 4'd2; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
         end
      join
      verify("font_start", 4'd1, n, wb, me, mt);

      // Randomized directory entries; cpu write enable held high outside RUN.
      for (int i = 0; i < 4; i++) begin
         rs = 4'($urandom_range(0, 15));
         set_dir(rs, 16'($urandom), 16'($urandom_range(0, 40)));
         @(negedge clk);
         cpu_ram_addr = 16'h0300; cpu_ram_din = 8'h77; cpu_ram_we = 1'b1;
         issue_start(rs);
         wb = wr_total;
         wait_done(n);
         cpu_ram_we = 1'b0;
         verify($sformatf("rnd%0d", i), rs, n, wb, me, mt);
      end

      // Reset during PROG, then autostart with the current slot.
      set_dir(4'd9, 16'h5000, 16'h0100);
      set_dir(4'd10, 16'h6000, 16'h0008);
      issue_start(4'd9);
      repeat (4230) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_reset_status", {busy, cpu_run, load_err, trunc, bus.ram_we}, 5'b0);
      chk("mid_reset_addr", {bus.rom_addr, bus.ram_addr}, 32'h0);
      slot = 4'd10;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1 wb = wr_total;
      wait_done(n);
      verify("rst_auto", 4'd10, n, wb, me, mt);

      chk("stray_we", stray, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
